// File: rtl/ram_wr_arbiter.sv
// ram_wr_arbiter: two-port write arbiter with a zero-fill sweep for an
// async-read register-file RAM. It registers the winning write onto the
// active-low cs_n/wr_n interface.
// Optional build macro RAM_WR_ARB_FIXED_PRIO_EN: port 0 always wins a tie,
// and the round-robin pointer is not built. Port 1 may then starve.
module ram_wr_arbiter #(
   parameter int data_width = 16,
   parameter int data_depth = 16,
   parameter int addr_width = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  req0,
   input  logic [addr_width-1:0] addr0,
   input  logic [data_width-1:0] data0,
   output logic                  gnt0,
   input  logic                  req1,
   input  logic [addr_width-1:0] addr1,
   input  logic [data_width-1:0] data1,
   output logic                  gnt1,
   output logic                  ram_cs_n,
   output logic                  ram_wr_n,
   output logic [addr_width-1:0] ram_wr_addr,
   output logic [data_width-1:0] ram_data_in,
   output logic                  busy
);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(data_depth - 1);

   state_t                state_q, state_d;
   logic [addr_width-1:0] cnt_q, cnt_d;
   logic                  cs_n_d, wr_n_d, busy_d;
   logic [addr_width-1:0] addr_d, sel_addr;
   logic [data_width-1:0] data_d, sel_data;
   logic                  pick1;
`ifndef RAM_WR_ARB_FIXED_PRIO_EN
   logic                  last_q, last_d;   // port granted most recently
`endif

   // Tie-break: with both requesting, round-robin favours the port that
   // did not win last; fixed priority always favours port 0.
   always_comb begin
`ifdef RAM_WR_ARB_FIXED_PRIO_EN
      pick1 = req1 && !req0;
`else
      pick1 = req1 && (!req0 || !last_q);
`endif
      sel_addr = pick1 ? addr1 : addr0;
      sel_data = pick1 ? data1 : data0;
   end

   // Next state, grants and next registered RAM-interface values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy;
      cs_n_d  = 1'b1;
      wr_n_d  = 1'b1;
      addr_d  = ram_wr_addr;
      data_d  = ram_data_in;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
`ifndef RAM_WR_ARB_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         S_CLEAR: begin
            if (clear) begin
               // The sweep restarts from address 0 on the next cycle.
               cnt_d  = '0;
               busy_d = 1'b1;
            end else begin
               cs_n_d = 1'b0;
               wr_n_d = 1'b0;
               addr_d = cnt_q;
               data_d = '0;
               if (cnt_q == LAST_ADDR) begin
                  state_d = S_RUN;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_RUN: begin
            if (clear) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else if (req0 || req1) begin
               gnt1   = pick1;
               gnt0   = !pick1;
               addr_d = sel_addr;
               data_d = sel_data;
               // An out-of-range address is consumed but never reaches the RAM.
               cs_n_d = !(int'(sel_addr) < data_depth);
               wr_n_d = !(int'(sel_addr) < data_depth);
`ifndef RAM_WR_ARB_FIXED_PRIO_EN
               last_d = pick1;
`endif
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // State, sweep counter and registered RAM write interface.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_CLEAR;
         cnt_q       <= '0;
         ram_cs_n    <= 1'b1;
         ram_wr_n    <= 1'b1;
         ram_wr_addr <= '0;
         ram_data_in <= '0;
         busy        <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ram_cs_n    <= cs_n_d;
         ram_wr_n    <= wr_n_d;
         ram_wr_addr <= addr_d;
         ram_data_in <= data_d;
         busy        <= busy_d;
      end
   end

`ifndef RAM_WR_ARB_FIXED_PRIO_EN
   // The round-robin pointer starts at 1, so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end
`endif

endmodule
